// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus definitions: bus widths, the sprite-DMA register
// address and the sprite-DMA sequencer state encoding.
package nes_bus_pkg;

    localparam int NES_ADDR_W = 16;
    localparam int NES_DATA_W = 8;

    localparam logic [15:0] OAM_DMA_REG = 16'h4014;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

endpackage : nes_bus_pkg

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA sequencer: a CPU write to DMA_REG_ADDR halts the CPU, takes
// the memory bus and copies XFER_LEN bytes from page {data,8'h00} into OAM
// starting at the OAMADDR value latched at trigger time.
//
// Optional feature macro: OAM_DMA_ALIGN_EN. When defined, a CPU-cycle
// parity bit is kept and an extra ALIGN cycle is inserted when HALT exits
// on an odd CPU cycle. When undefined there is no parity register and no
// ALIGN state.
module oam_dma_ctrl
    import nes_bus_pkg::*;
#(
    parameter int                ADDR_W       = NES_ADDR_W,
    parameter int                DATA_W       = NES_DATA_W,
    parameter int                XFER_LEN     = 256,
    parameter int                OAM_AW       = 8,
    parameter logic [ADDR_W-1:0] DMA_REG_ADDR = ADDR_W'(OAM_DMA_REG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_ce,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_wr,
    input  logic [OAM_AW-1:0] oam_base,
    output logic              rdy,
    output logic              bus_grant,
    output logic [ADDR_W-1:0] dma_addr,
    output logic              dma_rd,
    input  logic [DATA_W-1:0] dma_rdata,
    output logic [OAM_AW-1:0] oam_addr,
    output logic [DATA_W-1:0] oam_data,
    output logic              oam_we,
    output logic              oam_dma
);

    // Byte index width; a single-byte transfer still needs one bit.
    localparam int IDX_W = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
    // Low part of the read address below the page byte.
    localparam int LO_W  = ADDR_W - DATA_W;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    // Read address is the page byte followed by the zero-extended index;
    // the index never carries into the page.
    function automatic logic [ADDR_W-1:0] read_addr_of(
        input logic [DATA_W-1:0] pg,
        input logic [IDX_W-1:0]  i
    );
        return {pg, LO_W'(i)};
    endfunction

    // OAM destination wraps modulo 2^OAM_AW.
    function automatic logic [OAM_AW-1:0] oam_addr_of(
        input logic [OAM_AW-1:0] ob,
        input logic [IDX_W-1:0]  i
    );
        return ob + OAM_AW'(i);
    endfunction

    dma_state_t          state_r;
    logic [IDX_W-1:0]    idx_r;
    logic [DATA_W-1:0]   page_r;
    logic [OAM_AW-1:0]   ob_r;
    logic                trig_s;
    logic                last_s;

`ifdef OAM_DMA_ALIGN_EN
    logic                parity_r;
`endif

    // Trigger decode and end-of-transfer detect.
    always_comb begin
        trig_s = 1'b0;
        last_s = 1'b0;
        if (cpu_wr && (cpu_addr == DMA_REG_ADDR)) begin
            trig_s = 1'b1;
        end else begin
            trig_s = 1'b0;
        end
        if (idx_r == IDX_LAST) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

`ifdef OAM_DMA_ALIGN_EN
    // CPU-cycle parity: toggles on every CPU cycle from reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_r <= 1'b0;
        end else if (cpu_ce) begin
            parity_r <= ~parity_r;
        end
    end
`endif

    // Sequencer: state, counter, latched page/base and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            idx_r     <= IDX_ZERO;
            page_r    <= {DATA_W{1'b0}};
            ob_r      <= {OAM_AW{1'b0}};
            rdy       <= 1'b1;
            bus_grant <= 1'b0;
            dma_addr  <= {ADDR_W{1'b0}};
            dma_rd    <= 1'b0;
            oam_addr  <= {OAM_AW{1'b0}};
            oam_data  <= {DATA_W{1'b0}};
            oam_we    <= 1'b0;
            oam_dma   <= 1'b0;
        end else begin
            // The OAM strobe lasts one clk regardless of cpu_ce spacing.
            oam_we <= 1'b0;
            if (cpu_ce) begin
                case (state_r)
                    IDLE: begin
                        if (trig_s) begin
                            page_r  <= cpu_wdata;
                            ob_r    <= oam_base;
                            idx_r   <= IDX_ZERO;
                            rdy     <= 1'b0;
                            oam_dma <= 1'b1;
                            state_r <= HALT;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    HALT: begin
                        // The CPU write cycle has completed; the bus is ours.
                        bus_grant <= 1'b1;
`ifdef OAM_DMA_ALIGN_EN
                        if (parity_r) begin
                            state_r <= ALIGN;
                        end else begin
                            dma_addr <= read_addr_of(page_r, idx_r);
                            dma_rd   <= 1'b1;
                            state_r  <= READ;
                        end
`else
                        dma_addr <= read_addr_of(page_r, idx_r);
                        dma_rd   <= 1'b1;
                        state_r  <= READ;
`endif
                    end
`ifdef OAM_DMA_ALIGN_EN
                    ALIGN: begin
                        // Dummy cycle with no bus access to reach an even cycle.
                        dma_addr <= read_addr_of(page_r, idx_r);
                        dma_rd   <= 1'b1;
                        state_r  <= READ;
                    end
`endif
                    READ: begin
                        oam_data <= dma_rdata;
                        oam_addr <= oam_addr_of(ob_r, idx_r);
                        oam_we   <= 1'b1;
                        dma_rd   <= 1'b0;
                        state_r  <= WRITE;
                    end
                    WRITE: begin
                        if (last_s) begin
                            idx_r     <= IDX_ZERO;
                            rdy       <= 1'b1;
                            bus_grant <= 1'b0;
                            oam_dma   <= 1'b0;
                            state_r   <= IDLE;
                        end else begin
                            idx_r    <= idx_r + IDX_ONE;
                            dma_addr <= read_addr_of(page_r, idx_r + IDX_ONE);
                            dma_rd   <= 1'b1;
                            state_r  <= READ;
                        end
                    end
                    default: begin
                        // Unreachable encoding: fall back to a released bus.
                        idx_r     <= IDX_ZERO;
                        rdy       <= 1'b1;
                        bus_grant <= 1'b0;
                        dma_rd    <= 1'b0;
                        oam_dma   <= 1'b0;
                        state_r   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule : oam_dma_ctrl

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: RAM and OAM are modelled in the bench,
// every transfer result is compared against the bench's own RAM pattern.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_ce;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_wr;
    logic [7:0]  oam_base;
    logic        rdy;
    logic        bus_grant;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic [7:0]  dma_rdata;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        oam_we;
    logic        oam_dma;

    int compared   = 0;
    int mismatched = 0;
    int ce_since_rst = 0;
    int run_id = 0;
    int we_count = 0;

    logic [7:0] ram [65536];
    logic [7:0] oam_m [256];
    int         oam_stamp [256];

    always #5 clk = ~clk;

    oam_dma_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_ce    (cpu_ce),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wr    (cpu_wr),
        .oam_base  (oam_base),
        .rdy       (rdy),
        .bus_grant (bus_grant),
        .dma_addr  (dma_addr),
        .dma_rd    (dma_rd),
        .dma_rdata (dma_rdata),
        .oam_addr  (oam_addr),
        .oam_data  (oam_data),
        .oam_we    (oam_we),
        .oam_dma   (oam_dma)
    );

    assign dma_rdata = ram[dma_addr];

    // OAM model: capture every write strobe with the run it belongs to.
    always @(posedge clk) begin
        if (oam_we === 1'b1) begin
            oam_m[oam_addr]     <= oam_data;
            oam_stamp[oam_addr] <= run_id;
            we_count            <= we_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CPU cycle: cpu_ce high for one clk, then two idle clks.
    task automatic tick_ce();
        @(negedge clk);
        cpu_ce = 1'b1;
        @(negedge clk);
        cpu_ce = 1'b0;
        cpu_wr = 1'b0;
        ce_since_rst++;
        @(negedge clk);
    endtask

    task automatic run_xfer(input logic [7:0] pg, input logic [7:0] base,
                            input int retrig_at, input int stall_at, input int abort_at);
        int          align;
        int          lowcnt;
        int          first_rd;
        int          wc0;
        int          wc;
        int          bad;
        logic [15:0] first_addr;
        logic [15:0] a;
        logic [7:0]  k8;
        logic [7:0]  i8;
        bit          rt_done;
        bit          st_done;
        run_id++;
        wc0 = we_count;
        oam_base  = base;
        cpu_addr  = 16'h4014;
        cpu_wdata = pg;
        cpu_wr    = 1'b1;
        tick_ce();
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
`ifdef OAM_DMA_ALIGN_EN
        align = ce_since_rst % 2;
`else
        align = 0;
`endif
        check("trig_rdy", {31'd0, rdy}, 32'd0);
        check("trig_oam_dma", {31'd0, oam_dma}, 32'd1);
        check("halt_grant", {31'd0, bus_grant}, 32'd0);
        lowcnt = 0;
        first_rd = -1;
        first_addr = 16'h0000;
        rt_done = 1'b0;
        st_done = 1'b0;
        while (rdy === 1'b0 && lowcnt < 1200) begin
            if (dma_rd === 1'b1 && first_rd < 0) begin
                first_rd = lowcnt;
                first_addr = dma_addr;
            end
            if (dma_rd === 1'b1 && !rt_done && retrig_at >= 0 && dma_addr[7:0] == retrig_at[7:0]) begin
                rt_done   = 1'b1;
                cpu_addr  = 16'h4014;
                cpu_wdata = 8'h04;
                cpu_wr    = 1'b1;
                oam_base  = ~base;
            end
            if (dma_rd === 1'b1 && !st_done && stall_at >= 0 && dma_addr[7:0] == stall_at[7:0]) begin
                st_done = 1'b1;
                a  = dma_addr;
                wc = we_count;
                repeat (20) @(negedge clk);
                check("stall_addr", {16'd0, dma_addr}, {16'd0, a});
                check("stall_rd", {31'd0, dma_rd}, 32'd1);
                check("stall_we", we_count, wc);
            end
            if (dma_rd === 1'b1 && abort_at >= 0 && dma_addr[7:0] == abort_at[7:0]) begin
                reset = 1'b0;
                #1;
                check("abort_rdy", {31'd0, rdy}, 32'd1);
                check("abort_grant", {31'd0, bus_grant}, 32'd0);
                check("abort_oam_dma", {31'd0, oam_dma}, 32'd0);
                check("abort_dma_rd", {31'd0, dma_rd}, 32'd0);
                check("abort_dma_addr", {16'd0, dma_addr}, 32'd0);
                @(negedge clk);
                reset = 1'b1;
                ce_since_rst = 0;
                @(negedge clk);
                return;
            end
            tick_ce();
            lowcnt++;
        end
        check("rdy_low_cycles", lowcnt, 513 + align);
        check("first_rd_cycle", first_rd, 1 + align);
        check("first_rd_addr", {16'd0, first_addr}, {16'd0, pg, 8'h00});
        check("we_pulses", we_count - wc0, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            i8 = i[7:0];
            k8 = base + i8;
            if (oam_stamp[k8] != run_id || oam_m[k8] !== ram[{pg, i8}]) bad++;
        end
        check("oam_contents", bad, 0);
        check("done_grant", {31'd0, bus_grant}, 32'd0);
        check("done_oam_dma", {31'd0, oam_dma}, 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        cpu_ce    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        oam_base  = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ram[16'h0200 + i] = 8'(i) ^ 8'hA5;
            ram[16'h0300 + i] = 8'(i * 3 + 7);
            ram[16'h0400 + i] = ~8'(i);
            ram[16'h0500 + i] = 8'(i + 17);
            ram[16'h0600 + i] = 8'(i * 5 + 1);
            oam_stamp[i] = 0;
        end
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_rdy", {31'd0, rdy}, 32'd1);
        check("rst_grant", {31'd0, bus_grant}, 32'd0);
        check("rst_dma_rd", {31'd0, dma_rd}, 32'd0);
        check("rst_oam_we", {31'd0, oam_we}, 32'd0);
        check("rst_oam_dma", {31'd0, oam_dma}, 32'd0);
        check("rst_dma_addr", {16'd0, dma_addr}, 32'd0);
        check("rst_oam_addr", {24'd0, oam_addr}, 32'd0);
        check("rst_oam_data", {24'd0, oam_data}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // A write to a neighbouring register must not start DMA
        cpu_addr  = 16'h4015;
        cpu_wdata = 8'h02;
        cpu_wr    = 1'b1;
        tick_ce();
        check("no_trig_rdy", {31'd0, rdy}, 32'd1);
        check("no_trig_oam_dma", {31'd0, oam_dma}, 32'd0);

        // Basic copy of page 2 to OAM 0
        run_xfer(8'h02, 8'h00, -1, -1, -1);

        // Shift CPU-cycle parity, then wrapped copy of page 3 to OAM 0xF0
        tick_ce();
        run_xfer(8'h03, 8'hF0, -1, -1, -1);
        check("wrap_oam_F0", {24'd0, oam_m[8'hF0]}, {24'd0, ram[16'h0300]});
        check("wrap_oam_00", {24'd0, oam_m[8'h00]}, {24'd0, ram[16'h0310]});

        // Re-trigger at idx 10 and OAMADDR change mid-transfer are ignored
        run_xfer(8'h02, 8'h20, 10, -1, -1);

        // 20-clk cpu_ce stall during READ of idx 50
        run_xfer(8'h06, 8'h40, -1, 50, -1);

        // Reset asserted at idx 100, then a fresh transfer starts from idx 0
        run_xfer(8'h02, 8'h00, -1, -1, 100);
        run_xfer(8'h05, 8'h10, -1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_oam_dma_ctrl

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Parametrised sprite-DMA engine between the CPU bus and PPU OAM.
- A CPU write to the DMA register starts a transfer. The block stalls the CPU via rdy, takes ownership of the CPU-side memory bus, and copies XFER_LEN bytes from page {data,8'h00} into OAM starting at oam_base.
- It replaces the bare oam_dma/oam_addr/oam_data_in wiring at the CPU top level with a real sequencer.

Parameters:
- ADDR_W, 16, CPU address width
- DATA_W, 8, data width
- XFER_LEN, 256, bytes per transfer (power of 2, ≤256)
- OAM_AW, 8, OAM address width
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_ce  in  1  one-clk pulse marking one CPU cycle; all sequencing advances only on cpu_ce
- cpu_addr  in  ADDR_W  CPU address bus
- cpu_wdata  in  DATA_W  CPU write data
- cpu_wr  in  1  CPU write strobe, qualified by cpu_ce
- oam_base  in  OAM_AW  current PPU OAMADDR
- rdy  out  1  CPU ready, active low (0 = CPU halted)
- bus_grant  out  1  1 = DMA drives the memory bus
- dma_addr  out  ADDR_W  DMA read address
- dma_rd  out  1  DMA read request
- dma_rdata  in  DATA_W  memory read data, valid on the cpu_ce after dma_rd
- oam_addr  out  OAM_AW  OAM write address
- oam_data  out  DATA_W  OAM write data
- oam_we  out  1  OAM write strobe, one clk wide
- oam_dma  out  1  high while the transfer is active (HALT through last WRITE)

Behaviour:
- Reset values (async, on reset=0): state IDLE, rdy=1, bus_grant=0, dma_rd=0, oam_we=0, oam_dma=0, dma_addr=0, oam_addr=0, oam_data=0, idx=0, page=0.
- Trigger: in IDLE, cpu_ce & cpu_wr & cpu_addr==DMA_REG_ADDR latches page=cpu_wdata, ob=oam_base, goes to HALT.
  - rdy drops to 0 the clk after the triggering cpu_ce.
- HALT: one CPU cycle, lets the CPU write cycle complete. Next cpu_ce: to ALIGN or READ (see Optional Feature). bus_grant=1 from HALT exit.
- READ: dma_addr={page, idx zero-extended}, dma_rd=1. Next cpu_ce: capture dma_rdata into oam_data, go to WRITE.
- WRITE: oam_addr=ob+idx (mod 2^OAM_AW, wraps), oam_we=1 for exactly the first clk of WRITE.
  - Next cpu_ce: if idx==XFER_LEN-1, go to IDLE. Otherwise idx+=1 and go to READ.
- Counter: idx width = clog2(XFER_LEN). Address arithmetic is truncated, never carries into page.
- On return to IDLE: rdy=1, bus_grant=0, oam_dma=0 on the same clk. idx clears.
- Cycle count without the feature: 1 + 2·XFER_LEN CPU cycles (513 at default).
- Writes to DMA_REG_ADDR while not IDLE are ignored; no restart, no page change.
- cpu_ce low holds all state. Outputs are stable between pulses, except oam_we, which is a single-clk pulse.
- oam_base changes mid-transfer have no effect, because it is latched at trigger.
- Reset asserted mid-transfer: immediate abort to the reset values, CPU released. No partial-state resume.

Optional Feature:
- Macro: OAM_DMA_ALIGN_EN.
- Enabled:
  - A CPU-cycle parity bit toggles on every cpu_ce (reset 0).
  - If HALT exits on an odd cycle (parity=1), insert one ALIGN cycle (rdy=0, no bus access) before READ.
  - Transfer is then 514 cycles on odd starts and 513 on even starts.
- Disabled: no parity register and no ALIGN state. Always 513 cycles.

Decomposition:
- Shared package nes_bus_pkg:
  - dma_state_t enum {IDLE, HALT, ALIGN, READ, WRITE}
  - constant OAM_DMA_REG = 16'h4014
  - DATA_W / ADDR_W defaults
- No sub-module is needed; the FSM plus counter stay in one module.

Test Plan:
- Basic copy: preload RAM 0x0200–0x02FF with i^8'hA5, oam_base=0, write 8'h02 to 0x4014 -> OAM[i]=i^8'hA5 for all 256 entries; rdy low exactly 513 cpu_ce (feature off).
- Wrap: oam_base=8'hF0, page 0x03 -> RAM 0x0300 lands at OAM 0xF0, RAM 0x0310 at OAM 0x00; 256 oam_we pulses total.
- Parity (OAM_DMA_ALIGN_EN): trigger so HALT exits on odd cycle -> 514 low-rdy cycles, first dma_rd one cycle later than the even-start case.
- Re-trigger while busy: write 0x04 to 0x4014 at idx=10 -> ignored, page stays 0x02, transfer completes normally.
- Stall: hold cpu_ce low for 20 clks during READ -> dma_addr/dma_rd held, no oam_we, and the transfer resumes correctly.
- Reset mid-transfer: assert reset at idx=100 -> rdy=1, bus_grant=0, oam_dma=0 asynchronously; the next trigger starts from idx=0.
